// File: rtl/pc_sequencer.sv
// Fetch sequencer for the tau front end: drives the program counter's load/enable,
// fetches over a req/ack memory port and presents words to decode with valid/ready.
`timescale 1ns/1ps
module pc_sequencer #(
    parameter int                       ADDRESS_WIDTH = 16,
    parameter int                       DATA_WIDTH    = 16,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] pc,
    output logic                     pc_load_n,
    output logic                     pc_enable,
    output logic [ADDRESS_WIDTH-1:0] pc_target,
    output logic                     mem_req,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic                     mem_ack,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    input  logic                     branch_valid,
    input  logic [ADDRESS_WIDTH-1:0] branch_target,
    input  logic                     halt,
    output logic                     halted
);

    typedef enum logic [2:0] {
        BOOT     = 3'd0,
        FETCH    = 3'd1,
        ISSUE    = 3'd2,
        REDIRECT = 3'd3,
        HALTED   = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    instr_q, instr_d;
    logic [ADDRESS_WIDTH-1:0] redirect_q, redirect_d;
    logic                     pending_q, pending_d;
    logic                     pc_load_n_q, pc_load_n_d;
    logic [ADDRESS_WIDTH-1:0] pc_target_q, pc_target_d;
    logic                     mem_req_q, mem_req_d;
    logic                     instr_valid_q, instr_valid_d;
    logic                     halted_q, halted_d;

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        redirect_d = redirect_q;
        pending_d  = pending_q;
        unique case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                // The memory transaction always runs to its ack, even when a branch
                // has already made its data useless.
                if (branch_valid) begin
                    redirect_d = branch_target;
                    pending_d  = 1'b1;
                end
                if (mem_ack) begin
                    if (pending_q || branch_valid) begin
                        state_d = REDIRECT;
                    end else begin
                        instr_d = mem_rdata;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (branch_valid) begin
                    redirect_d = branch_target;
                    pending_d  = 1'b1;
                    instr_d    = '0;
                    state_d    = REDIRECT;
                end else if (instr_ready) begin
                    state_d = halt ? HALTED : FETCH;
                end
            end
            REDIRECT: begin
                if (branch_valid) begin
                    redirect_d = branch_target;
                end else begin
                    pending_d = 1'b0;
                    state_d   = FETCH;
                end
            end
            HALTED: if (!halt) state_d = FETCH;
            default: state_d = BOOT;
        endcase
    end

    // Outputs are registered from the next state so they change cleanly on the edge.
    always_comb begin
        pc_load_n_d   = !((state_d == BOOT) || (state_d == REDIRECT));
        pc_target_d   = (state_d == BOOT) ? RESET_VECTOR : redirect_d;
        mem_req_d     = (state_d == FETCH);
        instr_valid_d = (state_d == ISSUE);
        halted_d      = (state_d == HALTED);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= BOOT;
            instr_q       <= '0;
            redirect_q    <= RESET_VECTOR;
            pending_q     <= 1'b0;
            pc_load_n_q   <= 1'b0;
            pc_target_q   <= RESET_VECTOR;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            redirect_q    <= redirect_d;
            pending_q     <= pending_d;
            pc_load_n_q   <= pc_load_n_d;
            pc_target_q   <= pc_target_d;
            mem_req_q     <= mem_req_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    // Increment only for a fetch whose data is kept; never overlaps a load.
    assign pc_enable   = (state_q == FETCH) && mem_ack && !pending_q && !branch_valid;
    assign pc_load_n   = pc_load_n_q;
    assign pc_target   = pc_target_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = pc;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: a counter model, a memory model and a
// transaction-level program-flow model feeding an instruction scoreboard.
`timescale 1ns/1ps
module tb_pc_sequencer;
    localparam int              AW = 16;
    localparam int              DW = 16;
    localparam logic [AW-1:0]   RV = 16'h0010;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] pc;
    logic          pc_load_n, pc_enable;
    logic [AW-1:0] pc_target;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] instr;
    logic          instr_valid, instr_ready;
    logic          branch_valid;
    logic [AW-1:0] branch_target;
    logic          halt, halted;

    pc_sequencer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RESET_VECTOR(RV)) dut (
        .clock(clock), .reset(reset), .pc(pc),
        .pc_load_n(pc_load_n), .pc_enable(pc_enable), .pc_target(pc_target),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .halt(halt), .halted(halted)
    );

    always #5 clock = ~clock;

    // Program counter (counter_w_load) model
    initial pc = 16'hDEAD;
    always @(posedge clock) begin
        if (!pc_load_n)     pc <= pc_target;
        else if (pc_enable) pc <= pc + 16'd1;
    end

    int n_vec = 0;
    int n_bad = 0;
    logic [DW-1:0] exp_q[$];

    logic [AW-1:0] model_pc, fetch_addr, br_t;
    bit  fetch_active, fetch_branched, exp_redirect, exp_halted;
    bit  allow_branch, quiet, hold_ack;
    int  wait_cnt;

    bit            mon_prev = 1'b0;
    logic [DW-1:0] mon_held = '0;

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        logic [DW-1:0] p;
        p = a * 16'h9E37;
        return p ^ 16'h5A5A;
    endfunction

    function automatic logic [AW-1:0] rand_target();
        if ($urandom_range(3) == 0) return 16'hFFFF;
        return 16'($urandom);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        logic [AW-1:0] t;
        bit exp_en;
        @(negedge clock);
        exp_en = 1'b0;
        chk("halted_flag", 32'(halted), 32'(exp_halted));
        branch_valid  = 1'b0;
        mem_ack       = 1'b0;
        branch_target = 16'($urandom);
        if (exp_redirect) begin
            chk("redir_load_n", 32'(pc_load_n), 32'(0));
            chk("redir_target", 32'(pc_target), 32'(model_pc));
            chk("redir_no_req", 32'(mem_req), 32'(0));
            if (allow_branch && $urandom_range(3) == 0) begin
                t = rand_target();
                branch_valid = 1'b1; branch_target = t; model_pc = t;
            end else begin
                exp_redirect = 1'b0;
            end
        end else if (exp_halted) begin
            chk("halt_no_req", 32'(mem_req), 32'(0));
            branch_valid = 1'($urandom_range(1));
            if (quiet || $urandom_range(2) == 0) begin
                halt = 1'b0; exp_halted = 1'b0;
            end
        end else if (mem_req) begin
            if (!fetch_active) begin
                fetch_active = 1'b1; fetch_branched = 1'b0; fetch_addr = mem_addr;
                wait_cnt = hold_ack ? 1000 : (quiet ? 0 : int'($urandom_range(3)));
                chk("fetch_addr", 32'(mem_addr), 32'(model_pc));
            end else begin
                chk("addr_stable", 32'(mem_addr), 32'(fetch_addr));
            end
            halt = quiet ? 1'b0 : 1'($urandom_range(1));
            if (allow_branch && $urandom_range(4) == 0) begin
                t = rand_target();
                branch_valid = 1'b1; branch_target = t;
                fetch_branched = 1'b1; br_t = t;
            end
            if (wait_cnt == 0) begin
                mem_ack = 1'b1; mem_rdata = mem_fn(mem_addr); fetch_active = 1'b0;
                exp_en = !fetch_branched;
                if (fetch_branched) begin
                    model_pc = br_t; exp_redirect = 1'b1;
                end else begin
                    exp_q.push_back(mem_fn(model_pc));
                    model_pc = model_pc + 16'd1;
                end
            end else begin
                wait_cnt--;
                mem_rdata = 16'($urandom);
            end
        end else if (instr_valid) begin
            chk("issue_no_req", 32'(mem_req), 32'(0));
            instr_ready = quiet ? 1'b1 : 1'($urandom_range(1));
            halt        = quiet ? 1'b0 : ($urandom_range(5) == 0);
            if (allow_branch && $urandom_range(5) == 0) begin
                t = rand_target();
                branch_valid = 1'b1; branch_target = t; model_pc = t; exp_redirect = 1'b1;
            end else if (instr_ready && halt) begin
                exp_halted = 1'b1;
            end
        end else begin
            chk("stall_state", 32'({halted, mem_req, instr_valid}), 32'(3'b010));
        end
        #1;
        chk("load_en_excl", 32'(!pc_load_n && pc_enable), 32'(0));
        chk("pc_enable", 32'(pc_enable), 32'(exp_en));
    endtask

    task automatic reset_model();
        fetch_active = 1'b0; exp_redirect = 1'b0; exp_halted = 1'b0;
        model_pc = RV; branch_valid = 1'b0; mem_ack = 1'b0; halt = 1'b0;
        instr_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_load_n"}, 32'(pc_load_n), 32'(0));
        chk({tag, "_target"}, 32'(pc_target), 32'(RV));
        chk({tag, "_enable"}, 32'(pc_enable), 32'(0));
        chk({tag, "_req"},    32'(mem_req),   32'(0));
        chk({tag, "_valid"},  32'(instr_valid), 32'(0));
        chk({tag, "_halted"}, 32'(halted),    32'(0));
        chk({tag, "_instr"},  32'(instr),     32'(0));
    endtask

    // Scoreboard monitor: each new instruction presentation pops one expected word.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                mon_prev = 1'b0;
            end else if (instr_valid) begin
                if (!mon_prev) begin
                    if (exp_q.size() == 0) begin
                        chk("instr_unexpected", 32'(instr_valid), 32'(0));
                    end else begin
                        mon_held = exp_q.pop_front();
                        chk("instr_data", 32'(instr), 32'(mon_held));
                    end
                end else begin
                    chk("instr_hold", 32'(instr), 32'(mon_held));
                end
                mon_prev = 1'b1;
            end else begin
                mon_prev = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; branch_target = '0; mem_rdata = '0;
        allow_branch = 1'b0; quiet = 1'b0; hold_ack = 1'b0;
        reset_model();
        repeat (2) @(posedge clock);
        @(negedge clock); #1;
        check_reset_outputs("por");
        reset = 1'b0;

        allow_branch = 1'b1;
        repeat (1500) step();

        // Park a fetch waiting for ack, then reset in the middle of it.
        allow_branch = 1'b0; quiet = 1'b1; hold_ack = 1'b1;
        for (int i = 0; i < 40 && !fetch_active; i++) step();
        chk("reached_fetch", 32'(fetch_active), 32'(1));
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        chk("q_empty_at_reset", 32'(exp_q.size()), 32'(0));
        hold_ack = 1'b0; quiet = 1'b0;
        reset_model();
        repeat (2) @(posedge clock);
        @(negedge clock); #1;
        reset = 1'b0;

        allow_branch = 1'b1;
        repeat (800) step();

        allow_branch = 1'b0; quiet = 1'b1;
        repeat (30) step();
        if (exp_q.size() != 0) step();
        chk("queue_drain", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
